// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_hold;
    logic idex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NORM  = 5'b11000;
  localparam ctrl_t CTRL_HOLD  = 5'b00010;
  localparam ctrl_t CTRL_REDIR = 5'b11101;
  localparam ctrl_t CTRL_LU    = 5'b00001;
  localparam ctrl_t CTRL_RST   = 5'b00101;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_memread;
  logic             ex_br_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_hold;
  logic             idex_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_br_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_hold, idex_flush,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_br_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_hold, idex_flush,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the ID sources and the EX load target.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       use_rs1_i,
  input  logic       use_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_memread_i,
  output logic       lu_o
);
  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu_o = ex_memread_i && (ex_rd_i != REG_X0) &&
                ((use_rs1_i && (rs1_i == ex_rd_i)) ||
                 (use_rs2_i && (rs2_i == ex_rd_i)));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: memory freeze, branch redirect, load-use bubble,
// plus saturating stall and flush counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);
  state_e           state_q, state_d;
  logic             br_pend_q, br_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             lu;
  logic             redirect_req;
  logic             flush_evt;
  ctrl_t            ctrl;

  load_use_detect u_lu (
    .rs1_i        (bus.id_rs1),
    .rs2_i        (bus.id_rs2),
    .use_rs1_i    (bus.id_use_rs1),
    .use_rs2_i    (bus.id_use_rs2),
    .ex_rd_i      (bus.ex_rd),
    .ex_memread_i (bus.ex_memread),
    .lu_o         (lu)
  );

  // A redirect that arrived while memory was busy is kept in br_pend_q
  // and only honoured once the freeze lifts.
  assign redirect_req = bus.ex_br_taken || ((state_q == MEM_WAIT) && br_pend_q);

  always_comb begin
    ctrl      = CTRL_NORM;
    state_d   = RUN;
    br_pend_d = 1'b0;
    flush_evt = 1'b0;
    if (reset) begin
      ctrl = CTRL_RST;
    end else if (bus.mem_busy) begin
      ctrl      = CTRL_HOLD;
      state_d   = MEM_WAIT;
      br_pend_d = ((state_q == MEM_WAIT) && br_pend_q) || bus.ex_br_taken;
    end else if (redirect_req) begin
      ctrl      = CTRL_REDIR;
      flush_evt = 1'b1;
    end else if (lu) begin
      ctrl = CTRL_LU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      br_pend_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      br_pend_q <= br_pend_d;
      if (!ctrl.pc_write && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_write   = ctrl.pc_write;
  assign bus.ifid_write = ctrl.ifid_write;
  assign bus.ifid_flush = ctrl.ifid_flush;
  assign bus.idex_hold  = ctrl.idex_hold;
  assign bus.idex_flush = ctrl.idex_flush;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl, narrow counters to reach saturation.
module tb_hazard_ctrl;
  localparam int W = 4;
  localparam logic [4:0] NORM  = 5'b11000;
  localparam logic [4:0] HOLD  = 5'b00010;
  localparam logic [4:0] REDIR = 5'b11101;
  localparam logic [4:0] LUO   = 5'b00001;
  localparam logic [4:0] RST   = 5'b00101;

  typedef struct {
    logic [4:0] o;
    int         s;
    int         f;
  } exp_t;

  logic clk;
  logic reset;
  exp_t q[$];
  exp_t m;
  int   nchk = 0;
  int   nerr = 0;

  hazard_ctrl_if #(.CNT_W(W)) bus ();

  hazard_ctrl #(.CNT_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic v(input logic rst, input logic [4:0] rs1, input logic u1,
                   input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                   input logic mr, input logic br, input logic mb,
                   input logic [4:0] eo, input int es, input int ef);
    exp_t e;
    @(posedge clk);
    #1;
    reset              = rst;
    bus.id_rs1         = rs1;
    bus.id_use_rs1     = u1;
    bus.id_rs2         = rs2;
    bus.id_use_rs2     = u2;
    bus.ex_rd          = rd;
    bus.ex_memread     = mr;
    bus.ex_br_taken    = br;
    bus.mem_busy       = mb;
    e.o = eo;
    e.s = es;
    e.f = ef;
    q.push_back(e);
  endtask

  task automatic idle(input logic [4:0] eo, input int es, input int ef);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, eo, es, ef);
  endtask

  task automatic busy(input logic br, input logic [4:0] eo, input int es, input int ef);
    v(0, 0, 0, 0, 0, 0, 0, br, 1, eo, es, ef);
  endtask

  // Monitor: compares whatever expectation the driver queued for this cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      logic [4:0] act;
      m   = q.pop_front();
      act = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_hold, bus.idex_flush};
      nchk = nchk + 3;
      if (act !== m.o) begin
        nerr++;
        $display("FAIL ctrl @%0t: got %b expected %b", $time, act, m.o);
      end
      if ((^bus.stall_cnt === 1'bx) || (int'(bus.stall_cnt) != m.s)) begin
        nerr++;
        $display("FAIL stall_cnt @%0t: got %0d expected %0d", $time, bus.stall_cnt, m.s);
      end
      if ((^bus.flush_cnt === 1'bx) || (int'(bus.flush_cnt) != m.f)) begin
        nerr++;
        $display("FAIL flush_cnt @%0t: got %0d expected %0d", $time, bus.flush_cnt, m.f);
      end
    end
  end

  initial begin
    reset           = 1'b1;
    bus.id_rs1      = '0;
    bus.id_rs2      = '0;
    bus.id_use_rs1  = 1'b0;
    bus.id_use_rs2  = 1'b0;
    bus.ex_rd       = '0;
    bus.ex_memread  = 1'b0;
    bus.ex_br_taken = 1'b0;
    bus.mem_busy    = 1'b0;

    v(1, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0);
    idle(NORM, 0, 0);
    // load-use on rs1, then the ignored variants
    v(0, 5, 1, 0, 0, 5, 1, 0, 0, LUO,  0, 0);
    idle(NORM, 1, 0);
    v(0, 5, 1, 0, 0, 0, 1, 0, 0, NORM, 1, 0);
    v(0, 5, 0, 0, 0, 5, 1, 0, 0, NORM, 1, 0);
    v(0, 0, 0, 7, 1, 7, 1, 0, 0, LUO,  1, 0);
    idle(NORM, 2, 0);
    // redirect beats load-use
    v(0, 5, 1, 0, 0, 5, 1, 1, 0, REDIR, 2, 0);
    idle(NORM, 2, 1);
    // deferred redirect across a 3-cycle memory freeze
    v(1, 0, 0, 0, 0, 0, 0, 0, 0, RST, 2, 1);
    busy(1, HOLD, 0, 0);
    busy(0, HOLD, 1, 0);
    busy(0, HOLD, 2, 0);
    idle(REDIR, 3, 0);
    idle(NORM, 3, 1);
    idle(NORM, 3, 1);
    // reset in the second MEM_WAIT cycle drops the pending redirect
    busy(1, HOLD, 3, 1);
    v(1, 0, 0, 0, 0, 0, 0, 0, 1, RST, 4, 1);
    idle(NORM, 0, 0);
    idle(NORM, 0, 0);
    // branch arriving mid-freeze, then freeze exit into a load-use
    busy(0, HOLD, 0, 0);
    busy(1, HOLD, 1, 0);
    idle(REDIR, 2, 0);
    idle(NORM, 2, 1);
    busy(0, HOLD, 2, 1);
    v(0, 3, 1, 0, 0, 3, 1, 0, 0, LUO, 3, 1);
    idle(NORM, 4, 1);
    // stall counter saturation
    for (int i = 0; i < 20; i++)
      busy(0, HOLD, (4 + i > 15) ? 15 : 4 + i, 1);
    idle(NORM, 15, 1);
    idle(NORM, 15, 1);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the performance counters.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-005 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
REQ-006 ex_rd  in  5  destination register of the instruction in EX.
REQ-007 ex_memread  in  1  EX instruction is a load.
REQ-008 ex_br_taken  in  1  EX resolved a taken branch or jump; PC redirect valid this cycle.
REQ-009 mem_busy  in  1  data memory not ready; the whole pipeline must freeze.
REQ-010 pc_write  out  1  PC register enable.
REQ-011 ifid_write  out  1  IF/ID buffer write enable (drives its e_write).
REQ-012 ifid_flush  out  1  load NOP into IF/ID.
REQ-013 idex_hold  out  1  ID/EX register holds its contents.
REQ-014 idex_flush  out  1  load bubble (control zeroed) into ID/EX.
REQ-015 stall_cnt  out  CNT_W  cycles with pc_write=0 since reset.
REQ-016 flush_cnt  out  CNT_W  number of redirect flush events since reset.

Function
REQ-017 FSM states: RUN and MEM_WAIT, plus a one-bit br_pending register.
REQ-018 Load-use hazard (LU): ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-019 Priority within one cycle: mem_busy > redirect > LU > normal.
REQ-020 Normal: pc_write=1, ifid_write=1, ifid_flush=0, idex_hold=0, idex_flush=0.
REQ-021 RUN, mem_busy=1: pc_write=0, ifid_write=0, idex_hold=1, flushes 0; next MEM_WAIT; br_pending <= ex_br_taken.
REQ-022 RUN, redirect (ex_br_taken=1, mem_busy=0): pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1; stay RUN; flush_cnt +1.
REQ-023 RUN, LU (no redirect, no mem_busy): pc_write=0, ifid_write=0, idex_flush=1; one cycle per detection, no extra state.
REQ-024 MEM_WAIT, mem_busy=1: same outputs as REQ-021; br_pending <= br_pending | ex_br_taken.
REQ-025 MEM_WAIT, mem_busy=0: redirect if br_pending|ex_br_taken (outputs per REQ-022, flush_cnt +1, br_pending <= 0), else LU/normal evaluation; next RUN.
REQ-026 A deferred redirect is applied exactly once, on the first cycle mem_busy is low.
REQ-027 ifid_flush and idex_hold are never high together; idex_hold and idex_flush are never high together.
REQ-028 stall_cnt increments on every non-reset cycle with pc_write=0; both counters saturate at 2^CNT_W-1 and do not wrap.
REQ-029 Outputs are combinational from state, br_pending and current inputs; the decision latency is zero cycles.

Reset
REQ-030 While reset=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_hold=0, idex_flush=1.
REQ-031 On reset: state <= RUN, br_pending <= 0, stall_cnt <= 0, flush_cnt <= 0. Reset mid-MEM_WAIT discards a pending redirect.
REQ-032 In the first cycle after reset deassertion, the block evaluates as RUN with no history.

Structure
REQ-033 Package pipe_ctrl_pkg holds the state enum (RUN, MEM_WAIT) and the constant REG_X0=5'd0.
REQ-034 LU compare is a sub-module, load_use_detect, that is purely combinational. The FSM, br_pending and the counters stay in hazard_ctrl.

Verification
REQ-035 ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_write=0, ifid_write=0, idex_flush=1 for 1 cycle; stall_cnt=1.
REQ-036 Same as REQ-035 with ex_rd=0, or with id_use_rs1=0 -> normal outputs; stall_cnt unchanged.
REQ-037 ex_br_taken=1 together with LU -> redirect only (ifid_flush=1, idex_flush=1, pc_write=1); flush_cnt=1.
REQ-038 mem_busy high 3 cycles with ex_br_taken=1 in cycle 1 -> 3 hold cycles, then 1 redirect cycle; flush_cnt=1, stall_cnt=3.
REQ-039 Reset asserted during the 2nd MEM_WAIT cycle with br_pending=1 -> reset outputs per REQ-030; after release, normal outputs and no flush.
REQ-040 With CNT_W=4, 20 consecutive mem_busy cycles -> stall_cnt holds at 15.
